dma_channel_arbiter: RTL and testbench

Parametrised request/priority arbiter for the DMA controller. It generalises the fixed 4-channel request, mask and status registers to NUM_CH channels and adds the behaviour the datapath lacks: programmable DREQ/DACK sense, fixed or rotating priority, and a full HRQ/HLDA bus-hold handshake. It sits between the peripheral DREQ lines, the CPU bus-hold logic and the DMA datapath. It hands the datapath a latched channel number and receives transfer-done and terminal-count pulses back.

---
 rtl/dma_channel_arbiter_if.sv | 41 ++++
 rtl/dma_channel_arbiter.sv | 120 ++++++++++++
 tb/tb_dma_channel_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_channel_arbiter_if.sv
// rtl/dma_channel_arbiter_if.sv - request, grant and register bundle between DMA arbiter and its neighbours
interface dma_channel_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   dreq;
  logic                dreq_sense_high;
  logic                dack_sense_high;
  logic                rotating_priority;
  logic                mask_wr;
  logic [NUM_CH-1:0]   mask_data;
  logic                sw_req_wr;
  logic [CH_W-1:0]     sw_req_ch;
  logic                sw_req_set;
  logic                status_rd;
  logic                hlda;
  logic                xfer_done;
  logic                tc;
  logic                hrq;
  logic                grant_valid;
  logic [CH_W-1:0]     grant_ch;
  logic [NUM_CH-1:0]   dack;
  logic [NUM_CH-1:0]   mask_reg;
  logic [NUM_CH-1:0]   request_reg;
  logic [2*NUM_CH-1:0] status_reg;

  modport master (
    output dreq, dreq_sense_high, dack_sense_high, rotating_priority,
           mask_wr, mask_data, sw_req_wr, sw_req_ch, sw_req_set,
           status_rd, hlda, xfer_done, tc,
    input  hrq, grant_valid, grant_ch, dack, mask_reg, request_reg, status_reg
  );

  modport slave (
    input  dreq, dreq_sense_high, dack_sense_high, rotating_priority,
           mask_wr, mask_data, sw_req_wr, sw_req_ch, sw_req_set,
           status_rd, hlda, xfer_done, tc,
    output hrq, grant_valid, grant_ch, dack, mask_reg, request_reg, status_reg
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - DMA channel request/priority arbiter with HRQ/HLDA bus-hold handshake
module dma_channel_arbiter #(
  parameter int NUM_CH = 4
) (
  input logic                  clk,
  input logic                  rst,
  dma_channel_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic [NUM_CH-1:0] tc_q, tc_d;
  logic [NUM_CH-1:0] live_q;

  logic [NUM_CH-1:0] act, elig, grant_oh;
  logic [CH_W-1:0]   base, win_ch;
  logic              win_found;
  logic              done_svc;

  assign act  = (bus.dreq_sense_high ? bus.dreq : ~bus.dreq) | req_q;
  assign elig = act & ~mask_q;
  assign base = bus.rotating_priority ? ptr_q : '0;

  // Walk channels starting at base, wrapping modulo NUM_CH; first eligible wins.
  always_comb begin
    logic [CH_W:0] sum;
    sum       = '0;
    win_found = 1'b0;
    win_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, base} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!win_found && elig[sum[CH_W-1:0]]) begin
        win_found = 1'b1;
        win_ch    = sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    done_svc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) state_d = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (~|elig) begin
          state_d = IDLE;
        end else if (bus.hlda && win_found) begin
          state_d    = SERVICE;
          grant_ch_d = win_ch;
        end
      end
      SERVICE: begin
        // Completion takes precedence over a simultaneous hold drop.
        if (bus.xfer_done) begin
          state_d  = IDLE;
          done_svc = 1'b1;
        end else if (!bus.hlda) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d = bus.mask_wr ? bus.mask_data : mask_q;
    req_d  = req_q;
    tc_d   = bus.status_rd ? '0 : tc_q;
    ptr_d  = ptr_q;
    if (done_svc && bus.tc) begin
      req_d[grant_ch_q] = 1'b0;
      tc_d[grant_ch_q]  = 1'b1;
    end
    if (bus.sw_req_wr && ({1'b0, bus.sw_req_ch} < (CH_W+1)'(NUM_CH)))
      req_d[bus.sw_req_ch] = bus.sw_req_set;
    if (!bus.rotating_priority)
      ptr_d = '0;
    else if (done_svc)
      ptr_d = (grant_ch_q == CH_W'(NUM_CH-1)) ? '0 : grant_ch_q + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_ch_q <= '0;
      ptr_q      <= '0;
      mask_q     <= '1;
      req_q      <= '0;
      tc_q       <= '0;
      live_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      tc_q       <= tc_d;
      live_q     <= act;
    end
  end

  assign grant_oh        = (state_q == SERVICE) ? (NUM_CH'(1) << grant_ch_q) : '0;
  assign bus.hrq         = (state_q != IDLE);
  assign bus.grant_valid = (state_q == SERVICE);
  assign bus.grant_ch    = grant_ch_q;
  assign bus.dack        = bus.dack_sense_high ? grant_oh : ~grant_oh;
  assign bus.mask_reg    = mask_q;
  assign bus.request_reg = req_q;
  assign bus.status_reg  = {live_q, tc_q};
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - directed and randomized checks of dma_channel_arbiter against a transaction model
module tb_dma_channel_arbiter;
  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_channel_arbiter_if #(.NUM_CH(N)) bus ();
  dma_channel_arbiter #(.NUM_CH(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] m_mask, m_req, m_tc;
  int           m_ptr;
  bit           disturb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] act_f();
    return (bus.dreq_sense_high ? bus.dreq : ~bus.dreq) | m_req;
  endfunction

  function automatic int pick(input logic [N-1:0] e, input int start);
    for (int k = 0; k < N; k++)
      if (e[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_dack(input int w, input logic s);
    logic [N-1:0] oh;
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    return s ? oh : ~oh;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!bus.rotating_priority) m_ptr = 0;
    #1;
  endtask

  task automatic do_reset();
    bus.hlda = 1'b0; bus.xfer_done = 1'b0; bus.tc = 1'b0;
    bus.mask_wr = 1'b0; bus.sw_req_wr = 1'b0; bus.status_rd = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    m_mask = '1; m_req = '0; m_tc = '0; m_ptr = 0;
  endtask

  task automatic wr(input logic mw, input logic [N-1:0] md, input logic sw,
                    input logic [CW-1:0] sch, input logic sset);
    bus.mask_wr = mw; bus.mask_data = md;
    bus.sw_req_wr = sw; bus.sw_req_ch = sch; bus.sw_req_set = sset;
    step();
    bus.mask_wr = 1'b0; bus.sw_req_wr = 1'b0;
    if (mw) m_mask = md;
    if (sw) m_req[sch] = sset;
  endtask

  // One bus-hold transaction: request, hold grant, optional disturbance, then completion or abort.
  task automatic serve(input logic tc_v, input logic rd_v, input logic abort_v, output int got);
    logic [N-1:0] a, e;
    int w;
    logic sw_hit, sw_val;
    got = -1;
    a = act_f();
    e = a & ~m_mask;
    step();
    check("hrq_on", 32'(bus.hrq), 32'(|e));
    check("live_req", 32'(bus.status_reg[2*N-1:N]), 32'(a));
    if (e == '0) return;
    w = pick(e, bus.rotating_priority ? m_ptr : 0);
    bus.hlda = 1'b1;
    step();
    check("grant_valid", 32'(bus.grant_valid), 32'd1);
    check("grant_ch", 32'(bus.grant_ch), w);
    check("dack", 32'(bus.dack), 32'(exp_dack(w, bus.dack_sense_high)));
    got = w;
    if (disturb) repeat ($urandom_range(0, 3)) begin
      bus.dreq = N'($urandom);
      bus.dack_sense_high = 1'($urandom);
      bus.mask_wr = 1'($urandom);
      bus.mask_data = N'($urandom);
      if (bus.mask_wr) m_mask = bus.mask_data;
      step();
      bus.mask_wr = 1'b0;
      check("hold_ch", 32'(bus.grant_ch), w);
      check("hold_dack", 32'(bus.dack), 32'(exp_dack(w, bus.dack_sense_high)));
    end
    sw_hit = disturb && ($urandom_range(0, 2) == 0);
    sw_val = 1'($urandom);
    bus.sw_req_wr = sw_hit; bus.sw_req_ch = CW'(w); bus.sw_req_set = sw_val;
    if (abort_v) bus.hlda = 1'b0;
    else begin bus.xfer_done = 1'b1; bus.tc = tc_v; end
    bus.status_rd = rd_v;
    step();
    bus.sw_req_wr = 1'b0; bus.xfer_done = 1'b0; bus.tc = 1'b0;
    bus.status_rd = 1'b0; bus.hlda = 1'b0;
    if (rd_v) m_tc = '0;
    if (!abort_v && tc_v) begin m_tc[w] = 1'b1; m_req[w] = 1'b0; end
    if (sw_hit) m_req[w] = sw_val;
    if (!abort_v && bus.rotating_priority) m_ptr = (w + 1) % N;
    check("end_hrq", 32'(bus.hrq), 32'd0);
    check("end_gv", 32'(bus.grant_valid), 32'd0);
    check("end_dack", 32'(bus.dack), 32'(exp_dack(-1, bus.dack_sense_high)));
    check("tc_flags", 32'(bus.status_reg[N-1:0]), 32'(m_tc));
    check("req_reg", 32'(bus.request_reg), 32'(m_req));
  endtask

  initial begin
    int g;
    bus.dreq = '0; bus.dreq_sense_high = 1'b1; bus.dack_sense_high = 1'b1;
    bus.rotating_priority = 1'b0; bus.mask_data = '0; bus.sw_req_ch = '0;
    bus.sw_req_set = 1'b0;
    disturb = 1'b0;
    do_reset();
    check("rst_hrq", 32'(bus.hrq), 32'd0);
    check("rst_gv", 32'(bus.grant_valid), 32'd0);
    check("rst_gch", 32'(bus.grant_ch), 32'd0);
    check("rst_dack", 32'(bus.dack), 32'h00);
    check("rst_mask", 32'(bus.mask_reg), 32'hFF);
    check("rst_req", 32'(bus.request_reg), 32'd0);
    check("rst_status", 32'(bus.status_reg), 32'd0);
    bus.dack_sense_high = 1'b0; #1;
    check("rst_dack_low", 32'(bus.dack), 32'hFF);
    bus.dack_sense_high = 1'b1;

    wr(1'b1, '0, 1'b0, '0, 1'b0);
    bus.dreq = 8'h04;
    serve(1'b1, 1'b0, 1'b0, g);
    check("basic_ch", g, 2);
    check("basic_tc2", 32'(bus.status_reg[2]), 32'd1);

    bus.dreq = 8'h0A;
    for (int i = 0; i < 3; i++) begin serve(1'b0, 1'b0, 1'b0, g); check("fixed_ch", g, 1); end
    bus.rotating_priority = 1'b1;
    serve(1'b0, 1'b0, 1'b0, g); check("rot_ch0", g, 1);
    serve(1'b0, 1'b0, 1'b0, g); check("rot_ch1", g, 3);
    serve(1'b0, 1'b0, 1'b0, g); check("rot_ch2", g, 1);

    do_reset();
    wr(1'b1, '0, 1'b0, '0, 1'b0);
    bus.dreq = 8'hFF;
    for (int i = 0; i < 9; i++) begin serve(1'b0, 1'b0, 1'b0, g); check("wrap_ch", g, i % N); end

    bus.rotating_priority = 1'b0;
    bus.dreq_sense_high = 1'b0; bus.dack_sense_high = 1'b0;
    do_reset();
    check("rst_dack_lo", 32'(bus.dack), 32'hFF);
    wr(1'b1, 8'hFE, 1'b0, '0, 1'b0);
    bus.dreq = 8'hFE;
    serve(1'b0, 1'b0, 1'b0, g);
    check("lowsense_ch", g, 0);

    bus.dreq_sense_high = 1'b1; bus.dack_sense_high = 1'b1; bus.dreq = '0;
    wr(1'b1, '0, 1'b1, CW'(3), 1'b1);
    serve(1'b1, 1'b0, 1'b0, g);
    check("swreq_ch", g, 3);
    check("swreq_clr", 32'(bus.request_reg[3]), 32'd0);
    wr(1'b0, '0, 1'b1, CW'(0), 1'b1);
    serve(1'b1, 1'b1, 1'b0, g);
    check("rd_tc", 32'(bus.status_reg[N-1:0]), 32'h01);

    bus.rotating_priority = 1'b1; bus.dreq = 8'h11;
    serve(1'b0, 1'b0, 1'b1, g); check("abort_ch", g, 0);
    serve(1'b0, 1'b0, 1'b0, g); check("after_abort_ch", g, 0);
    serve(1'b0, 1'b0, 1'b0, g); check("after_done_ch", g, 4);

    bus.dreq = 8'h04;
    step();
    bus.hlda = 1'b1;
    step();
    check("mid_gv", 32'(bus.grant_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; bus.hlda = 1'b0;
    m_mask = '1; m_req = '0; m_tc = '0; m_ptr = 0;
    check("mid_rst_hrq", 32'(bus.hrq), 32'd0);
    check("mid_rst_dack", 32'(bus.dack), 32'h00);
    check("mid_rst_gch", 32'(bus.grant_ch), 32'd0);
    check("mid_rst_mask", 32'(bus.mask_reg), 32'hFF);

    disturb = 1'b1;
    for (int it = 0; it < 60; it++) begin
      bus.rotating_priority = 1'($urandom);
      bus.dreq_sense_high = 1'($urandom);
      bus.dack_sense_high = 1'($urandom);
      bus.dreq = N'($urandom);
      wr(1'($urandom), N'($urandom & $urandom), 1'($urandom), CW'($urandom), 1'($urandom));
      serve(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
